uart_core: RTL and testbench

Single-clock, fully parametrised UART core. It replaces the split TX/RX-clock UART with one clock domain, a runtime-programmable 16x oversampling baud divisor, a TX FIFO, valid/ready byte interfaces, and runtime frame format (parity none/even/odd, 1 or 2 stop bits). It sits between a host register/stream interface and the serial pins.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_if.sv | 30 +++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_core.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encodings, oversampling constants and parity.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE     = 16;
    localparam int MID_SAMPLE     = 7;
    localparam int MAX_DATA_WIDTH = 9;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    // Zero-extended upper bits do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_if
// Brief    : Host-side byte streams of the UART (TX push, RX pop + status).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_ready;
    logic                  rx_framing_error;
    logic                  rx_parity_error;
    logic                  rx_overrun;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_framing_error, rx_parity_error, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_framing_error, rx_parity_error, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO, first-word fall-through, wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_addr_w = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_addr_w:0]     r_wr_ptr;
    logic [c_addr_w:0]     r_rd_ptr;
    logic                  w_push;
    logic                  w_pop;

    assign o_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_addr_w+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_addr_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_wr_data;
    end
endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Brief    : Single-clock 16x-oversampled UART with TX FIFO and runtime format.
//            Optional UART_LOOPBACK_EN adds an internal tx->rx loopback port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_core #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx_busy,
    output logic                 tx,
    input  logic                 rx,
    uart_if.slave                bus
);
    import uart_pkg::*;

    localparam logic [4:0] c_bit_last   = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] c_stop2_last = 5'(2*OVERSAMPLE - 1);
    localparam logic [3:0] c_os_last    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_mid        = 4'(MID_SAMPLE);
    localparam logic [3:0] c_last_bit   = 4'(DATA_WIDTH - 1);

    // Divisor is latched at wrap so a shrinking value can never strand the counter.
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [DIV_WIDTH-1:0] r_div_lat;
    logic                 w_tick;

    assign w_tick = (r_div_cnt == r_div_lat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_div_lat <= baud_div;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_div_lat <= baud_div;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
        end
    end

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    tx_state_t             r_tx_state;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.tx_valid),
        .i_wr_data (bus.tx_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign bus.tx_ready = !w_fifo_full;
    assign w_pop        = (r_tx_state == TX_IDLE) && !w_fifo_empty;
    assign tx_busy      = (r_tx_state != TX_IDLE) || !w_fifo_empty;

    logic [4:0]            r_tx_cnt;
    logic [3:0]            r_tx_bit;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_tx_par_en;
    logic                  r_tx_two_stop;
    logic                  r_tx_par_bit;
    logic                  r_tx;
    logic                  w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_cnt ==
                          ((r_tx_state == TX_STOP && r_tx_two_stop) ? c_stop2_last : c_bit_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state    <= TX_IDLE;
            r_tx_cnt      <= '0;
            r_tx_bit      <= '0;
            r_tx_shift    <= '0;
            r_tx_par_en   <= 1'b0;
            r_tx_two_stop <= 1'b0;
            r_tx_par_bit  <= 1'b0;
            r_tx          <= 1'b1;
        end else begin
            if (r_tx_state != TX_IDLE && w_tick)
                r_tx_cnt <= w_tx_bit_end ? 5'd0 : r_tx_cnt + 5'd1;
            case (r_tx_state)
                TX_IDLE: if (!w_fifo_empty) begin
                    r_tx_shift    <= w_fifo_data;
                    r_tx_par_en   <= parity_en;
                    r_tx_two_stop <= two_stop;
                    r_tx_par_bit  <= calc_parity(MAX_DATA_WIDTH'(w_fifo_data), parity_odd);
                    r_tx_cnt      <= '0;
                    r_tx          <= 1'b0;
                    r_tx_state    <= TX_START;
                end
                TX_START: if (w_tx_bit_end) begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_bit   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: if (w_tx_bit_end) begin
                    if (r_tx_bit == c_last_bit) begin
                        r_tx       <= r_tx_par_en ? r_tx_par_bit : 1'b1;
                        r_tx_state <= r_tx_par_en ? TX_PARITY : TX_STOP;
                    end else begin
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx       <= r_tx_shift[1];
                        r_tx_bit   <= r_tx_bit + 4'd1;
                    end
                end
                TX_PARITY: if (w_tx_bit_end) begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: if (w_tx_bit_end) r_tx_state <= TX_IDLE;
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    logic w_rx_src;
`ifdef UART_LOOPBACK_EN
    assign tx       = loopback ? 1'b1 : r_tx;
    assign w_rx_src = loopback ? r_tx : rx;
`else
    assign tx       = r_tx;
    assign w_rx_src = rx;
`endif

    logic [1:0]            r_rx_sync;
    logic                  w_rxs;
    rx_state_t             r_rx_state;
    logic [3:0]            r_rx_cnt;
    logic [3:0]            r_rx_bit;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic                  r_rx_par_en;
    logic                  r_rx_par_odd;
    logic                  r_rx_par_bit;
    logic                  w_rx_sample;

    assign w_rxs       = r_rx_sync[1];
    assign w_rx_sample = w_tick && (r_rx_cnt == c_os_last);

    always_ff @(posedge clk) begin
        if (rst) r_rx_sync <= 2'b11;
        else     r_rx_sync <= {r_rx_sync[0], w_rx_src};
    end

    // After the mid-start alignment the 4-bit count wraps 15->0 on each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state           <= RX_IDLE;
            r_rx_cnt             <= '0;
            r_rx_bit             <= '0;
            r_rx_shift           <= '0;
            r_rx_par_en          <= 1'b0;
            r_rx_par_odd         <= 1'b0;
            r_rx_par_bit         <= 1'b0;
            bus.rx_valid         <= 1'b0;
            bus.rx_data          <= '0;
            bus.rx_framing_error <= 1'b0;
            bus.rx_parity_error  <= 1'b0;
            bus.rx_overrun       <= 1'b0;
        end else begin
            bus.rx_overrun <= 1'b0;
            if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (w_tick && !w_rxs) begin
                    r_rx_cnt     <= '0;
                    r_rx_par_en  <= parity_en;
                    r_rx_par_odd <= parity_odd;
                    r_rx_state   <= RX_START;
                end
                RX_START: if (w_tick) begin
                    if (r_rx_cnt == c_mid) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 4'd1;
                    end
                end
                RX_DATA: if (w_tick) begin
                    r_rx_cnt <= r_rx_cnt + 4'd1;
                    if (w_rx_sample) begin
                        r_rx_shift <= {w_rxs, r_rx_shift[DATA_WIDTH-1:1]};
                        if (r_rx_bit == c_last_bit)
                            r_rx_state <= r_rx_par_en ? RX_PARITY : RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 4'd1;
                    end
                end
                RX_PARITY: if (w_tick) begin
                    r_rx_cnt <= r_rx_cnt + 4'd1;
                    if (w_rx_sample) begin
                        r_rx_par_bit <= w_rxs;
                        r_rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: if (w_tick) begin
                    r_rx_cnt <= r_rx_cnt + 4'd1;
                    if (w_rx_sample) begin
                        if (!bus.rx_valid || bus.rx_ready) begin
                            bus.rx_valid         <= 1'b1;
                            bus.rx_data          <= r_rx_shift;
                            bus.rx_framing_error <= !w_rxs;
                            bus.rx_parity_error  <= r_rx_par_en && (r_rx_par_bit !=
                                calc_parity(MAX_DATA_WIDTH'(r_rx_shift), r_rx_par_odd));
                        end else begin
                            bus.rx_overrun <= 1'b1;
                        end
                        r_rx_state <= w_rxs ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: if (w_rxs) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core
// Brief    : Directed self-checking bench for uart_core (baud_div=3, 64 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div   = 16'd3;
    logic        parity_en  = 1'b0;
    logic        parity_odd = 1'b0;
    logic        two_stop   = 1'b0;
    logic        tx_busy;
    logic        tx;
    logic        rx;
    logic        rx_drv   = 1'b1;
    logic        loop_sel = 1'b0;

    always #5 clk = ~clk;

    assign rx = loop_sel ? tx : rx_drv;

    uart_if #(.DATA_WIDTH(8)) bus ();

    uart_core #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .DIV_WIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_busy    (tx_busy),
        .tx         (tx),
        .rx         (rx),
        .bus        (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         valid_cnt = 0;
    int         ovr_cnt   = 0;
    logic [7:0] rxq [$];

    always @(negedge clk) begin
        if (bus.rx_valid) valid_cnt++;
        if (bus.rx_overrun) ovr_cnt++;
        if (bus.rx_valid && bus.rx_ready) rxq.push_back(bus.rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (tx && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, 1);
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pen, input logic pbit,
                           input logic sbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (!bus.rx_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.rx_valid, 1);
    endtask

    task automatic ack();
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic fe,
                              input logic pe);
        wait_rx(tag);
        chk({tag, "_data"}, bus.rx_data, d);
        chk({tag, "_fe"}, bus.rx_framing_error, fe);
        chk({tag, "_pe"}, bus.rx_parity_error, pe);
        ack();
    endtask

    initial begin
        logic [9:0] exp_frame;
        int         base;
        int         v0;
        int         o0;
        int         n;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_tx", tx, 1);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_fe", bus.rx_framing_error, 0);
        chk("rst_pe", bus.rx_parity_error, 0);
        chk("rst_ovr", bus.rx_overrun, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // 8N1 0xA5: start, LSB-first data, stop
        exp_frame = {1'b1, 8'hA5, 1'b0};
        push(8'hA5);
        wait_tx_low("a5");
        repeat (30) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), tx, exp_frame[k]);
            if (k < 9) repeat (64) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        chk("a5_busy_late", tx_busy, 1);
        repeat (4) @(negedge clk);
        chk("a5_busy_done", tx_busy, 0);
        chk("a5_idle", tx, 1);

        // External loopback, 8E2
        loop_sel  = 1'b1;
        parity_en = 1'b1;
        two_stop  = 1'b1;
        repeat (10) @(negedge clk);
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        check_word("lb00", 8'h00, 1'b0, 1'b0);
        check_word("lbFF", 8'hFF, 1'b0, 1'b0);
        check_word("lb3C", 8'h3C, 1'b0, 1'b0);
        repeat (1000) @(negedge clk);
        loop_sel = 1'b0;
        two_stop = 1'b0;

        // 8O1 0x55: correct odd parity bit is 1, send 0
        parity_odd = 1'b1;
        repeat (50) @(negedge clk);
        send_rx(8'h55, 1'b1, 1'b0, 1'b1);
        check_word("par", 8'h55, 1'b0, 1'b1);
        repeat (100) @(negedge clk);

        send_rx(8'h55, 1'b1, 1'b1, 1'b0);
        check_word("frm", 8'h55, 1'b1, 1'b0);
        v0 = valid_cnt;
        repeat (1500) @(negedge clk);
        chk("break_hold", valid_cnt - v0, 0);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        send_rx(8'h0F, 1'b1, 1'b1, 1'b1);
        check_word("post_brk", 8'h0F, 1'b0, 1'b0);

        // Overrun with consumer stalled, 8N1
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        repeat (100) @(negedge clk);
        o0 = ovr_cnt;
        send_rx(8'h11, 1'b0, 1'b0, 1'b1);
        send_rx(8'h22, 1'b0, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        chk("ovr_valid", bus.rx_valid, 1);
        chk("ovr_data", bus.rx_data, 8'h11);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        ack();
        chk("ovr_clear", bus.rx_valid, 0);

        // FIFO fill: one frame in flight, then 17 back-to-back pushes
        loop_sel     = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (10) @(negedge clk);
        base = rxq.size();
        push(8'h80);
        wait_tx_low("prime");
        repeat (5) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            bus.tx_data  = 8'(i + 1);
            bus.tx_valid = 1'b1;
            if (i == 15) chk("fifo_ready15", bus.tx_ready, 1);
            if (i == 16) chk("fifo_full16", bus.tx_ready, 0);
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        n = 0;
        while (((rxq.size() - base) < 17 || tx_busy) && n < 15000) begin
            @(negedge clk);
            n++;
        end
        repeat (1000) @(negedge clk);
        chk("fifo_count", rxq.size() - base, 17);
        chk("fifo_w0", (base < rxq.size()) ? rxq[base] : 8'hEE, 8'h80);
        for (int i = 0; i < 16; i++)
            chk($sformatf("fifo_w%0d", i + 1),
                (base + 1 + i < rxq.size()) ? rxq[base + 1 + i] : 8'hEE, 8'(i + 1));
        chk("fifo_busy_end", tx_busy, 0);
        bus.rx_ready = 1'b0;
        loop_sel     = 1'b0;
        repeat (100) @(negedge clk);

        // Reset mid-data-bit with a word still queued
        push(8'h33);
        wait_tx_low("rst_frame");
        push(8'h44);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_ready", bus.tx_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("postrst_tx", tx, 1);
        chk("postrst_busy", tx_busy, 0);

        // 5-tick low glitch must be rejected as a false start
        v0 = valid_cnt;
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (1500) @(negedge clk);
        chk("glitch_no_valid", valid_cnt - v0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
